// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles every non-clock/reset signal of the UART receive buffer.
//   master : the UART receiver + host reader side (drives rx_* , rd_en, clears)
//   slave  : the receive buffer itself (drives head entry, status, statistics)
// Signals:
//   rx_done_tick / rx_data / rx_parity_error / rx_frame_error : receiver side
//   rd_en / rd_data / rd_parity_err / rd_frame_err             : FWFT read port
//   empty / full / almost_full / count                         : fill status
//   overrun / clr_overrun                                      : sticky drop flag
//   parity_err_cnt / frame_err_cnt / clr_stats                 : error statistics
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rx_done_tick;
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity_error;
    logic              rx_frame_error;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic              rd_frame_err;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              clr_overrun;
    logic [7:0]        parity_err_cnt;
    logic [7:0]        frame_err_cnt;
    logic              clr_stats;

    modport master (
        output rx_done_tick, rx_data, rx_parity_error, rx_frame_error,
        output rd_en, clr_overrun, clr_stats,
        input  rd_data, rd_parity_err, rd_frame_err,
        input  empty, full, almost_full, count,
        input  overrun, parity_err_cnt, frame_err_cnt
    );

    modport slave (
        input  rx_done_tick, rx_data, rx_parity_error, rx_frame_error,
        input  rd_en, clr_overrun, clr_stats,
        output rd_data, rd_parity_err, rd_frame_err,
        output empty, full, almost_full, count,
        output overrun, parity_err_cnt, frame_err_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind the UART receiver. Each character is captured on
// the receiver's done pulse, combined one cycle later with the (late) frame
// error flag, and committed into a first-word-fall-through FIFO. Also keeps a
// sticky overrun flag and saturating parity/frame error counters.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : uart_rx_fifo_if.slave (receiver inputs, read port, status, stats)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRY_W = DATA_W + 2;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_LVL_C = (ADDR_W+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [0:0] {
        CAP_IDLE   = 1'b0,
        CAP_COMMIT = 1'b1
    } cap_state_e;

    // Saturating 8-bit increment for the error statistics.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    cap_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_par_q, hold_par_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        par_cnt_q, par_cnt_d;
    logic [7:0]        frm_cnt_q, frm_cnt_d;

    logic               commit_s;
    logic               full_s;
    logic               empty_s;
    logic               wr_s;
    logic               drop_s;
    logic               rd_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;

    // Capture FSM: latch data/parity on the tick, commit in the following cycle.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_par_d  = hold_par_q;
        commit_s    = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (bus.rx_done_tick) begin
                    hold_data_d = bus.rx_data;
                    hold_par_d  = bus.rx_parity_error;
                    state_d     = CAP_COMMIT;
                end else begin
                    state_d     = CAP_IDLE;
                end
            end
            CAP_COMMIT: begin
                // The frame flag from the receiver is only valid now.
                commit_s = 1'b1;
                state_d  = CAP_IDLE;
            end
            default: begin
                state_d = CAP_IDLE;
            end
        endcase
    end

    // FIFO pointer/count/status next-state logic.
    always_comb begin
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == {(ADDR_W+1){1'b0}});
        entry_s = {bus.rx_frame_error, hold_par_q, hold_data_q};
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_s    = commit_s && (!full_s || bus.rd_en);
        drop_s  = commit_s && full_s && !bus.rd_en;
        rd_s    = bus.rd_en && !empty_s;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new drop outranks a simultaneous clear.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        // Statistics count every commit, dropped ones included; clear wins.
        if (bus.clr_stats) begin
            par_cnt_d = 8'd0;
            frm_cnt_d = 8'd0;
        end else if (commit_s) begin
            par_cnt_d = hold_par_q ? sat_inc8(par_cnt_q) : par_cnt_q;
            frm_cnt_d = bus.rx_frame_error ? sat_inc8(frm_cnt_q) : frm_cnt_q;
        end else begin
            par_cnt_d = par_cnt_q;
            frm_cnt_d = frm_cnt_q;
        end
    end

    // State, pointer, count, status and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CAP_IDLE;
            hold_data_q <= {DATA_W{1'b0}};
            hold_par_q  <= 1'b0;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {(ADDR_W+1){1'b0}};
            overrun_q   <= 1'b0;
            par_cnt_q   <= 8'd0;
            frm_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_par_q  <= hold_par_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            par_cnt_q   <= par_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    // FWFT head: present the oldest entry, or zeros when nothing is stored.
    always_comb begin
        if (empty_s) begin
            head_s = {ENTRY_W{1'b0}};
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
    end

    assign bus.rd_data        = head_s[DATA_W-1:0];
    assign bus.rd_parity_err  = head_s[DATA_W];
    assign bus.rd_frame_err   = head_s[DATA_W+1];
    assign bus.empty          = empty_s;
    assign bus.full           = full_s;
    assign bus.almost_full    = (count_q >= AF_LVL_C);
    assign bus.count          = count_q;
    assign bus.overrun        = overrun_q;
    assign bus.parity_err_cnt = par_cnt_q;
    assign bus.frame_err_cnt  = frm_cnt_q;

endmodule
